// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the multiplexed display scan driver.
//   scan_state_t : scan FSM states (BLANK = all anodes off, SHOW = one digit lit)
//   AN_OFF       : all-ones anode vector wide enough for the largest display
//   *_DEFAULT    : default parameter values for display_scan_driver
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Widest supported display is 8 digits; users slice the low DIGITS bits.
    localparam logic [7:0] AN_OFF = 8'hFF;

    localparam int DIGITS_DEFAULT   = 4;
    localparam int DWELL_DEFAULT    = 50000;
    localparam int DEADTIME_DEFAULT = 500;
    localparam int CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/display_scan_driver_lz_mask.sv
// -----------------------------------------------------------------------------
// lz_mask
// Combinational leading-zero blank mask for the scan driver.
//   active : committed display value, nibble 0 = rightmost digit
//   lz_en  : 1 = blank leading zero digits
//   blank  : bit k = 1 when digit k must stay dark during its slot
// Digit 0 is never blanked so an all-zero value still shows a single "0".
// -----------------------------------------------------------------------------
module lz_mask #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] active,
    input  logic                lz_en,
    output logic [DIGITS-1:0]   blank
);

    logic [DIGITS-1:0] blank_s;
    logic              all_zero_s;

    // Walk from the most significant digit down; a digit is blanked while
    // every nibble from it upward is zero.
    always_comb begin
        blank_s    = '0;
        all_zero_s = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero_s = all_zero_s & (active[4*k +: 4] == 4'h0);
            blank_s[k] = lz_en & all_zero_s;
        end
    end

    assign blank = blank_s;

endmodule

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
// Time-multiplexes a latched multi-digit hex value onto one shared nibble bus
// for a 4-bit-to-7-segment decoder, with dead time between digits, tear-free
// updates at frame boundaries and optional leading-zero blanking.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   value      : hex value to display, nibble 0 = rightmost digit
//   load       : one-cycle strobe, captures value into the shadow register
//   lz_en      : 1 = blank leading zero digits
//   enable     : 0 = display dark and scan halted
//   pending    : shadow holds a value not yet shown
//   nibble     : digit code to the decoder (registered)
//   dig_an_n   : active-low common-anode enables, at most one low (registered)
//   frame_done : one-cycle pulse on each frame boundary
// -----------------------------------------------------------------------------
module display_scan_driver
    import display_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEFAULT,
    parameter int DWELL    = DWELL_DEFAULT,
    parameter int DEADTIME = DEADTIME_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic                lz_en,
    input  logic                enable,
    output logic                pending,
    output logic [3:0]          nibble,
    output logic [DIGITS-1:0]   dig_an_n,
    output logic                frame_done
);

    localparam int                IDX_W      = $clog2(DIGITS);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]  DEAD_LAST  = CNT_W'(DEADTIME - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];
    localparam logic [DIGITS-1:0] AN_DIGIT0  = {{(DIGITS-1){1'b0}}, 1'b1};

    scan_state_t         state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [4*DIGITS-1:0] shadow_r, shadow_s;
    logic [4*DIGITS-1:0] active_r, active_s;
    logic                pending_r, pending_s;
    logic                frame_done_r, frame_done_s;
    logic [3:0]          nibble_r, nibble_s;
    logic [DIGITS-1:0]   an_n_r, an_n_s;
    logic [DIGITS-1:0]   blank_s;
    logic                commit_s;

    lz_mask #(
        .DIGITS (DIGITS)
    ) u_lz_mask (
        .active (active_r),
        .lz_en  (lz_en),
        .blank  (blank_s)
    );

    // Next-state logic: scan FSM, dwell/dead-time counter, shadow/active handoff.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        idx_s        = idx_r;
        shadow_s     = shadow_r;
        active_s     = active_r;
        pending_s    = pending_r;
        frame_done_s = 1'b0;
        nibble_s     = nibble_r;
        an_n_s       = an_n_r;
        commit_s     = 1'b0;

        if (!enable) begin
            // Halted: park at the start of a frame; nothing is on screen so a
            // pending value can be committed without tearing.
            state_s  = BLANK;
            cnt_s    = '0;
            idx_s    = '0;
            an_n_s   = AN_ALL_OFF;
            commit_s = pending_r;
        end else begin
            case (state_r)
                BLANK: begin
                    an_n_s = AN_ALL_OFF;
                    if (cnt_r == DEAD_LAST) begin
                        cnt_s    = '0;
                        state_s  = SHOW;
                        nibble_s = active_r[{idx_r, 2'b00} +: 4];
                        if (blank_s[idx_r]) begin
                            an_n_s = AN_ALL_OFF;
                        end else begin
                            an_n_s = ~(AN_DIGIT0 << idx_r);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_r == DWELL_LAST) begin
                        cnt_s   = '0;
                        state_s = BLANK;
                        an_n_s  = AN_ALL_OFF;
                        if (idx_r == IDX_LAST) begin
                            // Frame boundary: the only point a new value may appear.
                            idx_s        = '0;
                            frame_done_s = 1'b1;
                            commit_s     = pending_r;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = BLANK;
                    cnt_s   = '0;
                    idx_s   = '0;
                    an_n_s  = AN_ALL_OFF;
                end
            endcase
        end

        if (commit_s) begin
            active_s  = shadow_r;
            pending_s = 1'b0;
        end else begin
            active_s = active_r;
        end

        // A load on the commit edge wins over the pending clear: active gets
        // the old shadow and the new value waits a further frame.
        if (load) begin
            shadow_s  = value;
            pending_s = 1'b1;
        end else begin
            shadow_s = shadow_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= BLANK;
            cnt_r        <= '0;
            idx_r        <= '0;
            shadow_r     <= '0;
            active_r     <= '0;
            pending_r    <= 1'b0;
            frame_done_r <= 1'b0;
            nibble_r     <= 4'h0;
            an_n_r       <= AN_ALL_OFF;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            shadow_r     <= shadow_s;
            active_r     <= active_s;
            pending_r    <= pending_s;
            frame_done_r <= frame_done_s;
            nibble_r     <= nibble_s;
            an_n_r       <= an_n_s;
        end
    end

    assign pending    = pending_r;
    assign nibble     = nibble_r;
    assign dig_an_n   = an_n_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_display_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_display_scan_driver
// Directed bench for display_scan_driver with DIGITS=4, DWELL=4, DEADTIME=2
// (digit period 6 cycles, frame period 24 cycles).
// -----------------------------------------------------------------------------
module tb_display_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        lz_en;
    logic        enable;
    logic        pending;
    logic [3:0]  nibble;
    logic [3:0]  dig_an_n;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_driver #(
        .DIGITS   (4),
        .DWELL    (4),
        .DEADTIME (2),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .lz_en      (lz_en),
        .enable     (enable),
        .pending    (pending),
        .nibble     (nibble),
        .dig_an_n   (dig_an_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame of stimulus plus the expected per-digit anodes/nibbles.
    // Load steps count clock edges from the frame start (1..24, 0 = none).
    typedef struct {
        int          ld1_step;
        logic [15:0] ld1_val;
        int          ld2_step;
        logic [15:0] ld2_val;
        logic        lz;
        logic        pend_end;
        logic [15:0] an_exp;   // digit d anode pattern at [4d+:4]
        logic [15:0] nib_exp;  // digit d nibble at [4d+:4]
    } frame_t;

    frame_t frames [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input frame_t f, input int fi);
        logic [15:0] an_v;
        logic [15:0] nib_v;
        int          d;
        int          p;
        an_v  = f.an_exp;
        nib_v = f.nib_exp;
        lz_en = f.lz;
        for (int j = 1; j <= 24; j++) begin
            if (j == f.ld1_step) begin
                load  = 1'b1;
                value = f.ld1_val;
            end else if (j == f.ld2_step) begin
                load  = 1'b1;
                value = f.ld2_val;
            end else begin
                load  = 1'b0;
                value = 16'hDEAD;
            end
            tick();
            load  = 1'b0;
            value = 16'hDEAD;
            d = (j - 1) / 6;
            p = (j - 1) % 6;
            if (p == 0 || p == 5) begin
                chk($sformatf("f%0d_s%0d_gap_an", fi, j), {12'h000, dig_an_n}, 16'h000F);
            end else begin
                chk($sformatf("f%0d_s%0d_an", fi, j), {12'h000, dig_an_n}, {12'h000, an_v[4*d +: 4]});
                chk($sformatf("f%0d_s%0d_nib", fi, j), {12'h000, nibble}, {12'h000, nib_v[4*d +: 4]});
            end
            chk($sformatf("f%0d_s%0d_fdone", fi, j), {15'h0000, frame_done}, {15'h0000, (j == 24)});
            if (j == 24) begin
                chk($sformatf("f%0d_pend_end", fi), {15'h0000, pending}, {15'h0000, f.pend_end});
            end else if (j == f.ld1_step || j == f.ld2_step) begin
                chk($sformatf("f%0d_s%0d_pend_load", fi, j), {15'h0000, pending}, 16'h0001);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        value  = 16'h0000;
        lz_en  = 1'b0;

        //                ld1  val1      ld2  val2      lz    pend  anodes     nibbles
        frames[0] = '{10, 16'h12AF,  0, 16'h0000, 1'b0, 1'b0, 16'h7BDE, 16'h0000};
        frames[1] = '{ 5, 16'h1111, 12, 16'h2222, 1'b0, 1'b0, 16'h7BDE, 16'h12AF};
        frames[2] = '{15, 16'h4444, 24, 16'h3333, 1'b0, 1'b1, 16'h7BDE, 16'h2222};
        frames[3] = '{ 0, 16'h0000,  0, 16'h0000, 1'b0, 1'b0, 16'h7BDE, 16'h4444};
        frames[4] = '{ 3, 16'h0030,  0, 16'h0000, 1'b0, 1'b0, 16'h7BDE, 16'h3333};
        frames[5] = '{ 2, 16'h0000,  0, 16'h0000, 1'b1, 1'b0, 16'hFFDE, 16'h0030};
        frames[6] = '{ 0, 16'h0000,  0, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 16'h0000};
        frames[7] = '{ 0, 16'h0000,  0, 16'h0000, 1'b0, 1'b0, 16'h7BDE, 16'h0000};

        // Reset state
        tick();
        tick();
        chk("rst_an",      {12'h000, dig_an_n},    16'h000F);
        chk("rst_nib",     {12'h000, nibble},      16'h0000);
        chk("rst_pending", {15'h0000, pending},    16'h0000);
        chk("rst_fdone",   {15'h0000, frame_done}, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_frame(frames[i], i);
        end

        // Drop enable during digit 2 SHOW
        repeat (15) tick();
        chk("pre_dis_an", {12'h000, dig_an_n}, 16'h000B);
        enable = 1'b0;
        tick();
        chk("dis_an",    {12'h000, dig_an_n},    16'h000F);
        chk("dis_fdone", {15'h0000, frame_done}, 16'h0000);
        load  = 1'b1;
        value = 16'h5678;
        tick();
        load  = 1'b0;
        value = 16'hDEAD;
        chk("dis_load_pend", {15'h0000, pending},  16'h0001);
        chk("dis_load_an",   {12'h000, dig_an_n},  16'h000F);
        tick();
        chk("dis_commit_pend", {15'h0000, pending},    16'h0000);
        chk("dis_commit_fd",   {15'h0000, frame_done}, 16'h0000);
        tick();
        chk("dis_hold_an", {12'h000, dig_an_n}, 16'h000F);

        // Re-enable: two dead-time cycles, then digit 0 of the new value
        enable = 1'b1;
        tick();
        chk("reen_gap_an", {12'h000, dig_an_n}, 16'h000F);
        tick();
        chk("reen_d0_an",  {12'h000, dig_an_n}, 16'h000E);
        chk("reen_d0_nib", {12'h000, nibble},   16'h0008);
        repeat (5) tick();
        tick();
        chk("reen_d1_an",  {12'h000, dig_an_n}, 16'h000D);
        chk("reen_d1_nib", {12'h000, nibble},   16'h0007);

        // Reset during digit 1 SHOW with a pending load
        load  = 1'b1;
        value = 16'h9ABC;
        tick();
        load  = 1'b0;
        value = 16'hDEAD;
        chk("pre_rst_pend", {15'h0000, pending}, 16'h0001);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_an",    {12'h000, dig_an_n},    16'h000F);
        chk("mid_rst_nib",   {12'h000, nibble},      16'h0000);
        chk("mid_rst_pend",  {15'h0000, pending},    16'h0000);
        chk("mid_rst_fdone", {15'h0000, frame_done}, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("post_rst_gap_an", {12'h000, dig_an_n}, 16'h000F);
        tick();
        chk("post_rst_d0_an",  {12'h000, dig_an_n}, 16'h000E);
        chk("post_rst_d0_nib", {12'h000, nibble},   16'h0000);
        repeat (5) tick();
        tick();
        chk("post_rst_d1_an",  {12'h000, dig_an_n}, 16'h000D);
        chk("post_rst_d1_nib", {12'h000, nibble},   16'h0000);
        chk("post_rst_pend",   {15'h0000, pending}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
